// File: rtl/ascon_cipher_collector.sv
// ---------------------------------------------------------------------------
// ascon_cipher_collector
//
// Receive-side companion to the ASCON encryption sequencer. Collects the
// cipher blocks and the tag of one ECG frame, presents the assembled frame
// in parallel, then streams {ciphertext, tag} MSB-first as bytes over a
// valid/ready interface toward the UART transmitter.
//
// Ports
//   clock_i        system clock, rising edge
//   resetb_i       asynchronous active-low reset
//   start_i        one-cycle pulse, arms a new capture (aborts any frame)
//   cipher_i       cipher block from the ASCON core
//   cipher_valid_i cipher block valid (level; only its rising edge counts)
//   tag_i          tag from the ASCON core
//   end_tag_i      tag valid
//   cipher_o       assembled ciphertext, block 0 in the top 64 bits
//   tag_o          captured tag
//   frame_valid_o  cipher_o/tag_o complete and stable
//   byte_o         stream byte
//   byte_valid_o   byte_o valid
//   byte_ready_i   downstream accepts the byte
//   busy_o         high whenever the collector is not idle
//   seq_err_o      sticky protocol-error flag, cleared by start_i
// ---------------------------------------------------------------------------
module ascon_cipher_collector #(
   parameter int NB_BLOCKS = 23,
   parameter int BLOCK_W   = 64,
   parameter int TAG_W     = 128
) (
   input  logic                         clock_i,
   input  logic                         resetb_i,
   input  logic                         start_i,
   input  logic [BLOCK_W-1:0]           cipher_i,
   input  logic                         cipher_valid_i,
   input  logic [TAG_W-1:0]             tag_i,
   input  logic                         end_tag_i,
   output logic [NB_BLOCKS*BLOCK_W-1:0] cipher_o,
   output logic [TAG_W-1:0]             tag_o,
   output logic                         frame_valid_o,
   output logic [7:0]                   byte_o,
   output logic                         byte_valid_o,
   input  logic                         byte_ready_i,
   output logic                         busy_o,
   output logic                         seq_err_o
);

   localparam int         CIPHER_W  = NB_BLOCKS * BLOCK_W;
   localparam int         FRAME_W   = CIPHER_W + TAG_W;
   localparam int         NB_BYTES  = FRAME_W / 8;
   localparam logic [4:0] LAST_BLK  = 5'(NB_BLOCKS - 1);
   localparam logic [7:0] LAST_BYTE = 8'(NB_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_WAIT_TAG = 2'd2,
      ST_STREAM   = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic                  cv_prev_r;
   logic                  cv_rise_s;
   logic                  xfer_s;
   logic [4:0]            word_cnt_r;
   logic [7:0]            byte_cnt_r;
   logic [CIPHER_W-1:0]   cipher_r;
   logic [TAG_W-1:0]      tag_r;
   logic [FRAME_W-1:0]    frame_s;
   logic                  frame_valid_r;
   logic [7:0]            byte_r;
   logic                  byte_valid_r;
   logic                  busy_r;
   logic                  seq_err_r;

   // Byte idx (0 = most significant) of the concatenated frame.
   function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                             input logic [7:0]         idx);
      logic [FRAME_W-1:0] shifted;
      shifted = frame << {idx, 3'b000};
      return shifted[FRAME_W-1 -: 8];
   endfunction

   assign frame_s = {cipher_r, tag_r};

   // Event decode: valid rising edge and accepted byte transfer.
   always_comb begin
      cv_rise_s = cipher_valid_i & ~cv_prev_r;
      xfer_s    = byte_valid_r & byte_ready_i;
   end

   // Next-state logic; start_i overrides every other event.
   always_comb begin
      state_nxt_s = state_r;
      if (start_i) begin
         state_nxt_s = ST_CAPTURE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s = ST_IDLE;
            end
            ST_CAPTURE: begin
               if (cv_rise_s && (word_cnt_r == LAST_BLK)) begin
                  state_nxt_s = ST_WAIT_TAG;
               end else begin
                  state_nxt_s = ST_CAPTURE;
               end
            end
            ST_WAIT_TAG: begin
               if (end_tag_i) begin
                  state_nxt_s = ST_STREAM;
               end else begin
                  state_nxt_s = ST_WAIT_TAG;
               end
            end
            ST_STREAM: begin
               if (xfer_s && (byte_cnt_r == LAST_BYTE)) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_STREAM;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State register plus registered busy flag tracking it.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
      end
   end

   // Previous cipher_valid_i level for rising-edge detection.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         cv_prev_r <= 1'b0;
      end else begin
         cv_prev_r <= cipher_valid_i;
      end
   end

   // Frame buffers, counters, byte stream and error flag.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         cipher_r      <= '0;
         tag_r         <= '0;
         frame_valid_r <= 1'b0;
         word_cnt_r    <= 5'd0;
         byte_cnt_r    <= 8'd0;
         byte_r        <= 8'd0;
         byte_valid_r  <= 1'b0;
         seq_err_r     <= 1'b0;
      end else if (start_i) begin
         // New capture (or abort of the current one) from a clean slate.
         cipher_r      <= '0;
         tag_r         <= '0;
         frame_valid_r <= 1'b0;
         word_cnt_r    <= 5'd0;
         byte_cnt_r    <= 8'd0;
         byte_r        <= 8'd0;
         byte_valid_r  <= 1'b0;
         seq_err_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               byte_valid_r <= 1'b0;
            end
            ST_CAPTURE: begin
               if (cv_rise_s) begin
                  for (int k = 0; k < NB_BLOCKS; k++) begin
                     if (word_cnt_r == 5'(k)) begin
                        cipher_r[CIPHER_W-1-BLOCK_W*k -: BLOCK_W] <= cipher_i;
                     end
                  end
                  word_cnt_r <= word_cnt_r + 5'd1;
               end
               // A tag before the last block is a protocol error; it is dropped.
               if (end_tag_i) begin
                  seq_err_r <= 1'b1;
               end
            end
            ST_WAIT_TAG: begin
               if (end_tag_i) begin
                  tag_r         <= tag_i;
                  frame_valid_r <= 1'b1;
                  byte_cnt_r    <= 8'd0;
                  byte_r        <= frame_byte(frame_s, 8'd0);
                  byte_valid_r  <= 1'b1;
               end
               if (cv_rise_s) begin
                  seq_err_r <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (xfer_s) begin
                  if (byte_cnt_r == LAST_BYTE) begin
                     byte_valid_r <= 1'b0;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 8'd1;
                     byte_r     <= frame_byte(frame_s, byte_cnt_r + 8'd1);
                  end
               end
               if (cv_rise_s) begin
                  seq_err_r <= 1'b1;
               end
            end
            default: begin
               byte_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign cipher_o      = cipher_r;
   assign tag_o         = tag_r;
   assign frame_valid_o = frame_valid_r;
   assign byte_o        = byte_r;
   assign byte_valid_o  = byte_valid_r;
   assign busy_o        = busy_r;
   assign seq_err_o     = seq_err_r;

endmodule

// File: tb/tb_ascon_cipher_collector.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ascon_cipher_collector. Expected frames are kept as
// an array of 64-bit blocks plus a tag; expected stream bytes are sliced from
// them arithmetically.
// ---------------------------------------------------------------------------
module tb_ascon_cipher_collector;

   logic          clock_i = 1'b0;
   logic          resetb_i;
   logic          start_i;
   logic [63:0]   cipher_i;
   logic          cipher_valid_i;
   logic [127:0]  tag_i;
   logic          end_tag_i;
   logic [1471:0] cipher_o;
   logic [127:0]  tag_o;
   logic          frame_valid_o;
   logic [7:0]    byte_o;
   logic          byte_valid_o;
   logic          byte_ready_i;
   logic          busy_o;
   logic          seq_err_o;

   always #5 clock_i = ~clock_i;

   ascon_cipher_collector dut (
      .clock_i        (clock_i),
      .resetb_i       (resetb_i),
      .start_i        (start_i),
      .cipher_i       (cipher_i),
      .cipher_valid_i (cipher_valid_i),
      .tag_i          (tag_i),
      .end_tag_i      (end_tag_i),
      .cipher_o       (cipher_o),
      .tag_o          (tag_o),
      .frame_valid_o  (frame_valid_o),
      .byte_o         (byte_o),
      .byte_valid_o   (byte_valid_o),
      .byte_ready_i   (byte_ready_i),
      .busy_o         (busy_o),
      .seq_err_o      (seq_err_o)
   );

   typedef struct {
      int         idx;
      logic [7:0] val;
   } spot_t;

   typedef struct {
      bit fixed_data;  // 1: block k = k, tag 0011..EEFF
      int hold;        // cycles cipher_valid_i stays high, 0 = random 1..3
      int ready_mode;  // 0 always ready, 1 pattern 1,0,0,1, 2 random
   } scen_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_blk [23];
   logic [127:0] exp_tag;
   logic [7:0]  rx [200];
   spot_t       spots [8];
   scen_t       scen [6];

   localparam logic [127:0] NOM_TAG = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] get_blk(input int k);
      return cipher_o[1471-64*k -: 64];
   endfunction

   // Byte n of {blocks, tag}, most significant first.
   function automatic logic [7:0] exp_byte(input int n);
      logic [63:0]  w;
      logic [127:0] t;
      if (n < 184) begin
         w = exp_blk[n/8] >> (56 - 8*(n%8));
         return w[7:0];
      end else begin
         t = exp_tag >> (120 - 8*(n-184));
         return t[7:0];
      end
   endfunction

   task automatic fill_model(input bit fixed_data);
      for (int k = 0; k < 23; k++) begin
         exp_blk[k] = fixed_data ? 64'(k) : {$urandom, $urandom};
      end
      exp_tag = fixed_data ? NOM_TAG : {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_blocks(input string tag_name);
      for (int k = 0; k < 23; k++) begin
         chk($sformatf("%s_blk%0d", tag_name, k), 128'(get_blk(k)), 128'(exp_blk[k]));
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clock_i); @(negedge clock_i);
      start_i = 1'b0;
      chk("start_busy", 128'(busy_o), 128'd1);
      chk("start_fvalid", 128'(frame_valid_o), 128'd0);
      chk("start_seqerr", 128'(seq_err_o), 128'd0);
      chk("start_cipher_zero", 128'(cipher_o != '0), 128'd0);
      chk("start_tag_zero", tag_o, 128'd0);
   endtask

   task automatic send_block(input logic [63:0] d, input int hold, input int k, input bit expect_cap);
      cipher_i       = d;
      cipher_valid_i = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clock_i); @(negedge clock_i);
         if (h == 0 && expect_cap) begin
            chk($sformatf("cap_blk%0d", k), 128'(get_blk(k)), 128'(d));
         end
         cipher_i = {$urandom, $urandom};
      end
      cipher_valid_i = 1'b0;
      @(posedge clock_i); @(negedge clock_i);
   endtask

   task automatic send_tag(input logic [127:0] t, input bit accept);
      tag_i     = t;
      end_tag_i = 1'b1;
      @(posedge clock_i); @(negedge clock_i);
      end_tag_i = 1'b0;
      tag_i     = {$urandom, $urandom, $urandom, $urandom};
      if (accept) begin
         chk("tag_o", tag_o, exp_tag);
         chk("tag_fvalid", 128'(frame_valid_o), 128'd1);
         chk("first_byte_valid", 128'(byte_valid_o), 128'd1);
         chk("first_byte", 128'(byte_o), 128'(exp_byte(0)));
      end else begin
         chk("early_tag_ignored", tag_o, 128'd0);
         chk("early_tag_fvalid", 128'(frame_valid_o), 128'd0);
         chk("early_tag_seqerr", 128'(seq_err_o), 128'd1);
      end
   endtask

   // Drain up to max_xfer bytes, checking each accepted byte and stall stability.
   task automatic run_stream(input int mode, input int max_xfer);
      int   n;
      int   cyc;
      bit   stalled;
      bit   r;
      logic [7:0] held;
      n = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
      while (n < max_xfer && cyc < 3000) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: r = ($urandom_range(0, 1) == 1);
         endcase
         byte_ready_i = r;
         if (byte_valid_o) begin
            if (stalled) chk("byte_stable", 128'(byte_o), 128'(held));
            if (r) begin
               chk($sformatf("byte%0d", n), 128'(byte_o), 128'(exp_byte(n)));
               rx[n] = byte_o;
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = byte_o;
            end
         end
         @(posedge clock_i); @(negedge clock_i);
         cyc++;
      end
      chk("xfer_count", 128'(n), 128'(max_xfer));
      byte_ready_i = 1'b1;
      if (max_xfer == 200) begin
         chk("end_byte_valid", 128'(byte_valid_o), 128'd0);
         chk("end_busy", 128'(busy_o), 128'd0);
         chk("end_fvalid_kept", 128'(frame_valid_o), 128'd1);
      end
   endtask

   task automatic run_frame(input scen_t s);
      int h;
      pulse_start();
      fill_model(s.fixed_data);
      for (int k = 0; k < 23; k++) begin
         h = (s.hold == 0) ? $urandom_range(1, 3) : s.hold;
         send_block(exp_blk[k], h, k, 1'b1);
      end
      chk("pre_tag_fvalid", 128'(frame_valid_o), 128'd0);
      chk("pre_tag_busy", 128'(busy_o), 128'd1);
      send_tag(exp_tag, 1'b1);
      check_blocks("frame");
      run_stream(s.ready_mode, 200);
      chk("frame_seqerr", 128'(seq_err_o), 128'd0);
      if (s.fixed_data) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("spot%0d", spots[i].idx), 128'(rx[spots[i].idx]), 128'(spots[i].val));
         end
      end
   endtask

   initial begin
      spots[0] = '{0,   8'h00};
      spots[1] = '{7,   8'h00};
      spots[2] = '{15,  8'h01};
      spots[3] = '{183, 8'h16};
      spots[4] = '{184, 8'h00};
      spots[5] = '{190, 8'h66};
      spots[6] = '{192, 8'h88};
      spots[7] = '{199, 8'hFF};

      scen[0] = '{1'b1, 1, 0};  // nominal
      scen[1] = '{1'b1, 4, 0};  // level-held valid, same frame
      scen[2] = '{1'b1, 1, 1};  // backpressure 1,0,0,1
      scen[3] = '{1'b0, 0, 2};
      scen[4] = '{1'b0, 2, 2};
      scen[5] = '{1'b0, 0, 1};

      resetb_i = 1'b0; start_i = 1'b0; cipher_i = 64'd0; cipher_valid_i = 1'b0;
      tag_i = 128'd0; end_tag_i = 1'b0; byte_ready_i = 1'b1;
      #3;
      chk("rst_busy", 128'(busy_o), 128'd0);
      chk("rst_fvalid", 128'(frame_valid_o), 128'd0);
      chk("rst_bvalid", 128'(byte_valid_o), 128'd0);
      chk("rst_seqerr", 128'(seq_err_o), 128'd0);
      chk("rst_cipher_zero", 128'(cipher_o != '0), 128'd0);
      chk("rst_tag", tag_o, 128'd0);
      @(negedge clock_i); @(negedge clock_i);
      resetb_i = 1'b1;
      @(negedge clock_i);

      for (int i = 0; i < 6; i++) begin
         run_frame(scen[i]);
      end

      // Protocol errors: early tag, then a spurious block edge in WAIT_TAG.
      pulse_start();
      fill_model(1'b0);
      for (int k = 0; k < 5; k++) send_block(exp_blk[k], 1, k, 1'b1);
      send_tag({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      for (int k = 5; k < 23; k++) send_block(exp_blk[k], 1, k, 1'b1);
      chk("err_seqerr_sticky", 128'(seq_err_o), 128'd1);
      chk("err_tag_still0", tag_o, 128'd0);
      send_block({$urandom, $urandom}, 1, 0, 1'b0);
      check_blocks("err");
      chk("err_busy", 128'(busy_o), 128'd1);
      send_tag(exp_tag, 1'b1);
      run_stream(2, 200);
      chk("err_seqerr_end", 128'(seq_err_o), 128'd1);

      // Tag arriving together with the last block edge.
      pulse_start();
      fill_model(1'b0);
      for (int k = 0; k < 22; k++) send_block(exp_blk[k], 1, k, 1'b1);
      cipher_i = exp_blk[22]; cipher_valid_i = 1'b1;
      tag_i = {$urandom, $urandom, $urandom, $urandom}; end_tag_i = 1'b1;
      @(posedge clock_i); @(negedge clock_i);
      cipher_valid_i = 1'b0; end_tag_i = 1'b0;
      chk("simul_blk22", 128'(get_blk(22)), 128'(exp_blk[22]));
      chk("simul_seqerr", 128'(seq_err_o), 128'd1);
      chk("simul_tag0", tag_o, 128'd0);
      chk("simul_fvalid", 128'(frame_valid_o), 128'd0);
      chk("simul_bvalid", 128'(byte_valid_o), 128'd0);
      @(posedge clock_i); @(negedge clock_i);
      send_tag(exp_tag, 1'b1);
      run_stream(0, 200);

      // Abort at block 10 after an error; restart must be clean.
      pulse_start();
      fill_model(1'b0);
      for (int k = 0; k < 5; k++) send_block(exp_blk[k], 1, k, 1'b1);
      send_tag({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      for (int k = 5; k < 10; k++) send_block(exp_blk[k], 1, k, 1'b1);
      pulse_start();
      fill_model(1'b0);
      for (int k = 0; k < 23; k++) send_block(exp_blk[k], 1, k, 1'b1);
      send_tag(exp_tag, 1'b1);
      check_blocks("abort");
      run_stream(1, 200);
      chk("abort_seqerr", 128'(seq_err_o), 128'd0);

      // Reset in the middle of the stream, between clock edges.
      pulse_start();
      fill_model(1'b1);
      for (int k = 0; k < 23; k++) send_block(exp_blk[k], 1, k, 1'b1);
      send_tag(exp_tag, 1'b1);
      run_stream(0, 50);
      #2 resetb_i = 1'b0;
      #1;
      chk("midrst_bvalid", 128'(byte_valid_o), 128'd0);
      chk("midrst_fvalid", 128'(frame_valid_o), 128'd0);
      chk("midrst_cipher_zero", 128'(cipher_o != '0), 128'd0);
      chk("midrst_busy", 128'(busy_o), 128'd0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock_i); @(negedge clock_i);
         chk("post_rst_no_byte", 128'(byte_valid_o), 128'd0);
      end

      run_frame(scen[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
